multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 19 +
 rtl/multicycle_ctrl.sv | 113 +++++++++++
 tb/tb_multicycle_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields, memory handshakes and datapath strobes between controller and datapath
interface multicycle_ctrl_if;
  logic [5:0] opcode, funct;
  logic       zero, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_wr, pc_wr, ir_wr, gpr_wr, alu_bsel, bmode, epc_wr;
  logic [2:0] npc_sel, state_o;
  logic [1:0] gpr_sel, wd_sel, ext_op, exc_code;
  logic [3:0] alu_op;
  modport master (
    input  opcode, funct, zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_wr, pc_wr, npc_sel, ir_wr, gpr_wr, gpr_sel, wd_sel,
           alu_op, alu_bsel, ext_op, bmode, epc_wr, exc_code, state_o
  );
  modport slave (
    output opcode, funct, zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_wr, pc_wr, npc_sel, ir_wr, gpr_wr, gpr_sel, wd_sel,
           alu_op, alu_bsel, ext_op, bmode, epc_wr, exc_code, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-subset control FSM with memory wait timeout and exceptions
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8,
  parameter bit EN_BNE  = 1'b1
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, EXC = 3'd5} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       exc_q, exc_d;
  logic rtype, addu, subu, slt, jr, ori, lui, addi, addiu, lw, lb, sw, sb, beq, bne, j, jal;
  logic alu_cls, ld, st, valid, timeout;
  assign rtype   = bus.opcode == 6'b000000;
  assign addu    = rtype && bus.funct == 6'b100001;
  assign subu    = rtype && bus.funct == 6'b100011;
  assign slt     = rtype && bus.funct == 6'b101010;
  assign jr      = rtype && bus.funct == 6'b001000;
  assign ori     = bus.opcode == 6'b001101;
  assign lui     = bus.opcode == 6'b001111;
  assign addi    = bus.opcode == 6'b001000;
  assign addiu   = bus.opcode == 6'b001001;
  assign lw      = bus.opcode == 6'b100011;
  assign lb      = bus.opcode == 6'b100000;
  assign sw      = bus.opcode == 6'b101011;
  assign sb      = bus.opcode == 6'b101000;
  assign beq     = bus.opcode == 6'b000100;
  assign bne     = EN_BNE && bus.opcode == 6'b000101;
  assign j       = bus.opcode == 6'b000010;
  assign jal     = bus.opcode == 6'b000011;
  assign alu_cls = addu | subu | slt | ori | lui | addi | addiu;
  assign ld      = lw | lb;
  assign st      = sw | sb;
  assign valid   = alu_cls | ld | st | beq | bne | j | jal | jr;
  assign timeout = cnt_q == LIMIT;
  assign bus.state_o  = state_q;
  assign bus.exc_code = exc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  always_comb begin
    state_d      = state_q;
    exc_d        = exc_q;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_wr  = 1'b0;
    bus.pc_wr    = 1'b0;
    bus.npc_sel  = 3'b000;
    bus.ir_wr    = 1'b0;
    bus.gpr_wr   = 1'b0;
    bus.gpr_sel  = 2'b00;
    bus.wd_sel   = 2'b11;
    bus.epc_wr   = 1'b0;
    bus.alu_op   = state_q == FETCH ? 4'd15 : (subu | beq | bne) ? 4'd1 : ori ? 4'd2 :
                   lui ? 4'd3 : addi ? 4'd5 : slt ? 4'd6 : 4'd0;
    bus.ext_op   = state_q == FETCH ? 2'b11 : lui ? 2'b10 : (ld | st | addi | addiu) ? 2'b01 : 2'b00;
    bus.alu_bsel = ori | lui | addi | addiu | ld | st;
    bus.bmode    = lb | sb;
    case (state_q)
      FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_wr    = bus.imem_ready & ~rst;
        bus.pc_wr    = bus.imem_ready & ~rst;
        state_d      = bus.imem_ready ? DECODE : timeout ? EXC : FETCH;
        exc_d        = bus.imem_ready ? 2'd0 : timeout ? 2'd2 : exc_q;
      end
      DECODE: begin
        state_d = valid ? EXEC : EXC;
        exc_d   = valid ? exc_q : 2'd1;
      end
      EXEC: begin
        state_d     = alu_cls ? WB : (ld | st) ? MEM : FETCH;
        bus.npc_sel = (beq | bne) ? 3'b001 : (j | jal) ? 3'b010 : jr ? 3'b100 : 3'b000;
        bus.pc_wr   = (beq & bus.zero) | (bne & ~bus.zero) | j | jal | jr;
        bus.gpr_wr  = jal;
        bus.gpr_sel = jal ? 2'b10 : 2'b00;
        bus.wd_sel  = jal ? 2'b10 : 2'b11;
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_wr  = st;
        state_d      = bus.dmem_ready ? (ld ? WB : FETCH) : timeout ? EXC : MEM;
        exc_d        = (~bus.dmem_ready & timeout) ? 2'd2 : exc_q;
      end
      WB: begin
        bus.gpr_wr  = 1'b1;
        bus.gpr_sel = rtype ? 2'b01 : 2'b00;
        bus.wd_sel  = ld ? 2'b01 : 2'b00;
        state_d     = FETCH;
      end
      EXC: begin
        bus.epc_wr  = 1'b1;
        bus.pc_wr   = 1'b1;
        bus.npc_sel = 3'b011;
        state_d     = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // the counter only advances while parked in a waiting state
    cnt_d = (state_d == state_q && (state_q == FETCH || state_q == MEM)) ? cnt_q + CNT_W'(1) : '0;
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven and directed checks of the multicycle controller
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  multicycle_ctrl_if aif ();
  multicycle_ctrl_if bif ();
  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8), .EN_BNE(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(aif.master));
  multicycle_ctrl #(.EN_BNE(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bif.master));
  assign bif.opcode     = aif.opcode;
  assign bif.funct      = aif.funct;
  assign bif.zero       = aif.zero;
  assign bif.imem_ready = aif.imem_ready;
  assign bif.dmem_ready = aif.dmem_ready;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_JAL = 6'h03, OP_BAD = 6'h3f, F_ADDU = 6'h21;
  // strobe order: imem_req dmem_req dmem_wr pc_wr ir_wr gpr_wr epc_wr
  localparam logic [6:0] S0 = 7'b0000000, SF = 7'b1000000, SFR = 7'b1001100, SM = 7'b0100000;
  localparam logic [6:0] SMW = 7'b0110000, SWB = 7'b0000010, SBR = 7'b0001000, SEXC = 7'b0001001, SJAL = 7'b0001010;
  typedef struct {
    logic r; logic [5:0] op, fn; logic z, ir, dr;
    logic [2:0] st; logic [6:0] s; logic [2:0] npc; logic [1:0] gs, wd, exc; logic [3:0] alu;
  } vec_t;
  typedef struct {logic [5:0] op, fn; logic [3:0] alu, dec;} dvec_t;
  vec_t  tbl[$];
  dvec_t dt[6];
  int checks = 0, failures = 0;
  task automatic v(input logic r, input logic [5:0] op, fn, input logic z, ir, dr, input logic [2:0] st,
                   input logic [6:0] s, input logic [2:0] npc, input logic [1:0] gs, wd, exc, input logic [3:0] alu);
    tbl.push_back('{r, op, fn, z, ir, dr, st, s, npc, gs, wd, exc, alu});
  endtask
  task automatic chk(input string name, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic logic [22:0] act_a();
    return {aif.state_o, aif.imem_req, aif.dmem_req, aif.dmem_wr, aif.pc_wr, aif.ir_wr, aif.gpr_wr, aif.epc_wr,
            aif.npc_sel, aif.gpr_sel, aif.wd_sel, aif.exc_code, aif.alu_op};
  endfunction
  task automatic to_decode(input logic [5:0] op, fn);
    rst = 1'b1;
    aif.opcode = op; aif.funct = fn; aif.zero = 1'b0; aif.imem_ready = 1'b1; aif.dmem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask
  initial begin
    aif.opcode = '0; aif.funct = '0; aif.zero = 1'b0; aif.imem_ready = 1'b0; aif.dmem_ready = 1'b0;
    // ADDU with all readies high
    v(1, OP_R, F_ADDU, 0, 1, 1, 0, SF,  0, 0, 3, 0, 15);
    v(0, OP_R, F_ADDU, 0, 1, 1, 0, SFR, 0, 0, 3, 0, 15);
    v(0, OP_R, F_ADDU, 0, 1, 1, 1, S0,  0, 0, 3, 0, 0);
    v(0, OP_R, F_ADDU, 0, 1, 1, 2, S0,  0, 0, 3, 0, 0);
    v(0, OP_R, F_ADDU, 0, 1, 1, 4, SWB, 0, 1, 0, 0, 0);
    v(0, OP_R, F_ADDU, 0, 1, 1, 0, SFR, 0, 0, 3, 0, 15);
    // LW with dmem_ready three cycles late
    v(1, OP_LW, 0, 0, 1, 0, 0, SF,  0, 0, 3, 0, 15);
    v(0, OP_LW, 0, 0, 1, 0, 0, SFR, 0, 0, 3, 0, 15);
    v(0, OP_LW, 0, 0, 1, 0, 1, S0,  0, 0, 3, 0, 0);
    v(0, OP_LW, 0, 0, 1, 0, 2, S0,  0, 0, 3, 0, 0);
    for (int k = 0; k < 3; k++) v(0, OP_LW, 0, 0, 1, 0, 3, SM, 0, 0, 3, 0, 0);
    v(0, OP_LW, 0, 0, 1, 1, 3, SM,  0, 0, 3, 0, 0);
    v(0, OP_LW, 0, 0, 1, 1, 4, SWB, 0, 0, 1, 0, 0);
    v(0, OP_LW, 0, 0, 1, 1, 0, SFR, 0, 0, 3, 0, 15);
    // BEQ zero=0, BEQ zero=1, BNE zero=0
    v(1, OP_BEQ, 0, 0, 1, 0, 0, SF,  0, 0, 3, 0, 15);
    v(0, OP_BEQ, 0, 0, 1, 0, 0, SFR, 0, 0, 3, 0, 15);
    v(0, OP_BEQ, 0, 0, 1, 0, 1, S0,  0, 0, 3, 0, 1);
    v(0, OP_BEQ, 0, 0, 1, 0, 2, S0,  1, 0, 3, 0, 1);
    v(0, OP_BEQ, 0, 0, 1, 0, 0, SFR, 0, 0, 3, 0, 15);
    v(1, OP_BEQ, 0, 1, 1, 0, 0, SF,  0, 0, 3, 0, 15);
    v(0, OP_BEQ, 0, 1, 1, 0, 0, SFR, 0, 0, 3, 0, 15);
    v(0, OP_BEQ, 0, 1, 1, 0, 1, S0,  0, 0, 3, 0, 1);
    v(0, OP_BEQ, 0, 1, 1, 0, 2, SBR, 1, 0, 3, 0, 1);
    v(1, OP_BNE, 0, 0, 1, 0, 0, SF,  0, 0, 3, 0, 15);
    v(0, OP_BNE, 0, 0, 1, 0, 0, SFR, 0, 0, 3, 0, 15);
    v(0, OP_BNE, 0, 0, 1, 0, 1, S0,  0, 0, 3, 0, 1);
    v(0, OP_BNE, 0, 0, 1, 0, 2, SBR, 1, 0, 3, 0, 1);
    v(0, OP_BNE, 0, 0, 1, 0, 0, SFR, 0, 0, 3, 0, 15);
    // SW with dmem_ready never arriving: timeout after TIMEOUT=4 wait cycles
    v(1, OP_SW, 0, 0, 1, 0, 0, SF,  0, 0, 3, 0, 15);
    v(0, OP_SW, 0, 0, 1, 0, 0, SFR, 0, 0, 3, 0, 15);
    v(0, OP_SW, 0, 0, 1, 0, 1, S0,  0, 0, 3, 0, 0);
    v(0, OP_SW, 0, 0, 1, 0, 2, S0,  0, 0, 3, 0, 0);
    for (int k = 0; k < 5; k++) v(0, OP_SW, 0, 0, 1, 0, 3, SMW, 0, 0, 3, 0, 0);
    v(0, OP_SW, 0, 0, 1, 0, 5, SEXC, 3, 0, 3, 2, 0);
    v(0, OP_SW, 0, 0, 0, 0, 0, SF,   0, 0, 3, 2, 15);
    v(0, OP_SW, 0, 0, 1, 0, 0, SFR,  0, 0, 3, 2, 15);
    v(0, OP_SW, 0, 0, 1, 0, 1, S0,   0, 0, 3, 0, 0);
    // SW with dmem_ready exactly in the TIMEOUT cycle is accepted
    v(1, OP_SW, 0, 0, 1, 0, 0, SF,  0, 0, 3, 0, 15);
    v(0, OP_SW, 0, 0, 1, 0, 0, SFR, 0, 0, 3, 0, 15);
    v(0, OP_SW, 0, 0, 1, 0, 1, S0,  0, 0, 3, 0, 0);
    v(0, OP_SW, 0, 0, 1, 0, 2, S0,  0, 0, 3, 0, 0);
    for (int k = 0; k < 4; k++) v(0, OP_SW, 0, 0, 1, 0, 3, SMW, 0, 0, 3, 0, 0);
    v(0, OP_SW, 0, 0, 1, 1, 3, SMW, 0, 0, 3, 0, 0);
    v(0, OP_SW, 0, 0, 1, 1, 0, SFR, 0, 0, 3, 0, 15);
    // JAL
    v(1, OP_JAL, 0, 0, 1, 0, 0, SF,   0, 0, 3, 0, 15);
    v(0, OP_JAL, 0, 0, 1, 0, 0, SFR,  0, 0, 3, 0, 15);
    v(0, OP_JAL, 0, 0, 1, 0, 1, S0,   0, 0, 3, 0, 0);
    v(0, OP_JAL, 0, 0, 1, 0, 2, SJAL, 2, 2, 2, 0, 0);
    v(0, OP_JAL, 0, 0, 1, 0, 0, SFR,  0, 0, 3, 0, 15);
    // undefined opcode
    v(1, OP_BAD, 0, 0, 1, 0, 0, SF,   0, 0, 3, 0, 15);
    v(0, OP_BAD, 0, 0, 1, 0, 0, SFR,  0, 0, 3, 0, 15);
    v(0, OP_BAD, 0, 0, 1, 0, 1, S0,   0, 0, 3, 0, 0);
    v(0, OP_BAD, 0, 0, 1, 0, 5, SEXC, 3, 0, 3, 1, 0);
    v(0, OP_BAD, 0, 0, 1, 0, 0, SFR,  0, 0, 3, 1, 15);
    v(0, OP_BAD, 0, 0, 1, 0, 1, S0,   0, 0, 3, 0, 0);
    // decode: {alu_bsel, ext_op, bmode}
    dt = '{'{6'h20, 6'h00, 4'd0, 4'b1011}, '{6'h0f, 6'h00, 4'd3, 4'b1100}, '{6'h0d, 6'h00, 4'd2, 4'b1000},
           '{6'h08, 6'h00, 4'd5, 4'b1010}, '{6'h00, 6'h2a, 4'd6, 4'b0000}, '{6'h28, 6'h00, 4'd0, 4'b1011}};
    #1 rst = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].r; aif.opcode = tbl[i].op; aif.funct = tbl[i].fn;
      aif.zero = tbl[i].z; aif.imem_ready = tbl[i].ir; aif.dmem_ready = tbl[i].dr;
      #1;
      chk($sformatf("vec%0d", i), 32'(act_a()),
          32'({tbl[i].st, tbl[i].s, tbl[i].npc, tbl[i].gs, tbl[i].wd, tbl[i].exc, tbl[i].alu}));
      @(negedge clk);
    end
    foreach (dt[i]) begin
      to_decode(dt[i].op, dt[i].fn);
      chk($sformatf("dec_alu%0d", i), 32'(aif.alu_op), 32'(dt[i].alu));
      chk($sformatf("dec_ctl%0d", i), 32'({aif.alu_bsel, aif.ext_op, aif.bmode}), 32'(dt[i].dec));
    end
    // BNE undefined when EN_BNE=0
    to_decode(OP_BNE, 6'h00);
    chk("b_decode", 32'(bif.state_o), 1);
    @(negedge clk); #1;
    chk("b_exc", 32'({bif.state_o, bif.exc_code}), 32'({3'd5, 2'd1}));
    chk("b_vec", 32'({bif.npc_sel, bif.epc_wr, bif.pc_wr}), 32'({3'b011, 2'b11}));
    chk("a_bne_exec", 32'(aif.state_o), 2);
    // reset asserted mid-MEM
    to_decode(OP_LW, 6'h00);
    @(negedge clk);
    @(negedge clk); #1;
    chk("mem_before_rst", 32'({aif.state_o, aif.dmem_req}), 32'({3'd3, 1'b1}));
    #2 rst = 1'b1;
    #1 chk("mem_rst", 32'({aif.state_o, aif.dmem_req, aif.dmem_wr, aif.exc_code}), 0);
    // reset clears a held exception code
    to_decode(OP_BAD, 6'h00);
    @(negedge clk);
    aif.imem_ready = 1'b0;
    @(negedge clk); #1;
    chk("exc_held", 32'({aif.state_o, aif.exc_code}), 32'({3'd0, 2'd1}));
    #2 rst = 1'b1;
    #1 chk("exc_rst", 32'(aif.exc_code), 0);
    chk("rst_fetch_out", 32'({aif.imem_req, aif.ext_op, aif.wd_sel, aif.alu_op}), 32'({1'b1, 2'b11, 2'b11, 4'hf}));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst", 32'({aif.state_o, aif.imem_req}), 32'({3'd0, 1'b1}));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
